// File: rtl/sigma_bus_arb2_pkg.sv
// sigma_bus_arb2_pkg: shared types for the two-master sigma system-bus arbiter.
//   mid_t   - master identifier carried through the read-response ID queue
//   state_e - arbiter lock state
//   M_CPU / M_UDM - identifiers of the CPU data port and the UDM debug master
package sigma_bus_arb2_pkg;

   typedef logic mid_t;

   typedef enum logic [0:0] {
      StIdle   = 1'b0,
      StLocked = 1'b1
   } state_e;

   localparam mid_t M_CPU = 1'b0;
   localparam mid_t M_UDM = 1'b1;

endpackage

// File: rtl/sigma_bus_arb2_idq.sv
// sigma_bus_arb2_idq: in-order ID queue recording which master issued each
// outstanding read, so slave responses can be routed back to it.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset (empties the queue)
//   push_i, id_i   enqueue an ID (accepted when not full, or when popping too)
//   pop_i          dequeue the head (ignored when empty)
//   id_o           head ID
//   full_o,empty_o occupancy flags
module sigma_bus_arb2_idq
   import sigma_bus_arb2_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic push_i,
   input  mid_t id_i,
   input  logic pop_i,
   output mid_t id_o,
   output logic full_o,
   output logic empty_o
);

   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);
   localparam logic [PtrW:0]   CntOne  = (PtrW + 1)'(1);
   localparam logic [PtrW:0]   CntFull = (PtrW + 1)'(DEPTH);

   mid_t            mem_q [DEPTH];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PtrW:0]   count_q, count_d;
   logic            do_push, do_pop;

   assign full_o  = (count_q == CntFull);
   assign empty_o = (count_q == '0);
   assign id_o    = mem_q[rd_ptr_q];

   // A push into a full queue is fine when the head leaves in the same cycle.
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      // Depth is a power of two, so pointers wrap by natural overflow.
      if (do_push) wr_ptr_d = wr_ptr_q + PtrOne;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrOne;
      unique case ({do_push, do_pop})
         2'b10:   count_d = count_q + CntOne;
         2'b01:   count_d = count_q - CntOne;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: entries are only read once the count covers them.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= id_i;
   end

endmodule

// File: rtl/sigma_bus_arb2.sv
// sigma_bus_arb2: shares one system-bus slave port between the CPU data port
// (m0) and the UDM debug master (m1). Round-robin or fixed-priority grant,
// grant held until the slave accepts, in-order read responses routed back to
// the issuing master through an ID queue.
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   mN_req/we/addr/be/wdata_i     master N request (held until mN_ack_o)
//   mN_ack_o                      master N request accepted this cycle
//   mN_resp_o, mN_rdata_o         master N read data valid / data
//   s_req/we/addr/be/wdata_o      request to slave (fields zero when idle)
//   s_ack_i                       slave accepted the request
//   s_resp_i, s_rdata_i           slave read data valid (in order) / data
//   grant_o                       current owner (0 = m0, 1 = m1)
//   err_o                         sticky: response seen with no read outstanding
module sigma_bus_arb2
   import sigma_bus_arb2_pkg::*;
#(
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned MAX_OUTST = 4,
   parameter bit          RR_EN     = 1'b1
) (
   input  logic                clk_i,
   input  logic                rst_i,

   input  logic                m0_req_i,
   input  logic                m0_we_i,
   input  logic [ADDR_W-1:0]   m0_addr_i,
   input  logic [DATA_W/8-1:0] m0_be_i,
   input  logic [DATA_W-1:0]   m0_wdata_i,
   output logic                m0_ack_o,
   output logic                m0_resp_o,
   output logic [DATA_W-1:0]   m0_rdata_o,

   input  logic                m1_req_i,
   input  logic                m1_we_i,
   input  logic [ADDR_W-1:0]   m1_addr_i,
   input  logic [DATA_W/8-1:0] m1_be_i,
   input  logic [DATA_W-1:0]   m1_wdata_i,
   output logic                m1_ack_o,
   output logic                m1_resp_o,
   output logic [DATA_W-1:0]   m1_rdata_o,

   output logic                s_req_o,
   output logic                s_we_o,
   output logic [ADDR_W-1:0]   s_addr_o,
   output logic [DATA_W/8-1:0] s_be_o,
   output logic [DATA_W-1:0]   s_wdata_o,
   input  logic                s_ack_i,
   input  logic                s_resp_i,
   input  logic [DATA_W-1:0]   s_rdata_i,

   output logic                grant_o,
   output logic                err_o
);

   localparam int unsigned BE_W = DATA_W / 8;

   state_e state_q, state_d;
   mid_t   grant_q, grant_d;
   mid_t   last_q, last_d;
   logic   err_q, err_d;

   logic   q_full, q_empty, q_push, q_pop;
   mid_t   q_head;

   logic   space, elig0, elig1, active, req_live, ack, resp_live;
   mid_t   owner;

   logic              own_we;
   logic [ADDR_W-1:0] own_addr;
   logic [BE_W-1:0]   own_be;
   logic [DATA_W-1:0] own_wdata;

   // Arbitration. A read is only eligible when the ID queue can take its ID,
   // counting a response that frees the head in this same cycle.
   always_comb begin
      q_pop  = s_resp_i & ~q_empty;
      space  = ~q_full | q_pop;
      elig0  = m0_req_i & (m0_we_i | space);
      elig1  = m1_req_i & (m1_we_i | space);
      owner  = grant_q;
      active = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (elig0 && elig1) begin
               owner = RR_EN ? ~last_q : M_CPU;
            end else if (elig1) begin
               owner = M_UDM;
            end else begin
               owner = M_CPU;
            end
            active = elig0 | elig1;
         end
         StLocked: begin
            // Owner is fixed; a pending read just waits for queue space.
            active = (grant_q == M_UDM) ? elig1 : elig0;
         end
      endcase
   end

   // Request field mux from the current owner.
   always_comb begin
      own_we    = (owner == M_UDM) ? m1_we_i    : m0_we_i;
      own_addr  = (owner == M_UDM) ? m1_addr_i  : m0_addr_i;
      own_be    = (owner == M_UDM) ? m1_be_i    : m0_be_i;
      own_wdata = (owner == M_UDM) ? m1_wdata_i : m0_wdata_i;
      req_live  = active & ~rst_i;
      ack       = req_live & s_ack_i;
      q_push    = ack & ~own_we;
      resp_live = q_pop & ~rst_i;
   end

   // Next-state: lock on an unaccepted request, release on accept.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      err_d   = err_q | (s_resp_i & q_empty);
      if (req_live) begin
         grant_d = owner;
         if (s_ack_i) begin
            state_d = StIdle;
            last_d  = owner;
         end else begin
            state_d = StLocked;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         grant_q <= M_CPU;
         last_q  <= M_UDM;  // so m0 wins the first tie
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         err_q   <= err_d;
      end
   end

   sigma_bus_arb2_idq #(
      .DEPTH (MAX_OUTST)
   ) u_idq (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (q_push),
      .id_i    (owner),
      .pop_i   (q_pop),
      .id_o    (q_head),
      .full_o  (q_full),
      .empty_o (q_empty)
   );

   always_comb begin
      s_req_o    = req_live;
      s_we_o     = req_live & own_we;
      s_addr_o   = req_live ? own_addr  : '0;
      s_be_o     = req_live ? own_be    : '0;
      s_wdata_o  = req_live ? own_wdata : '0;

      m0_ack_o   = ack & (owner == M_CPU);
      m1_ack_o   = ack & (owner == M_UDM);

      m0_resp_o  = resp_live & (q_head == M_CPU);
      m1_resp_o  = resp_live & (q_head == M_UDM);
      m0_rdata_o = m0_resp_o ? s_rdata_i : '0;
      m1_rdata_o = m1_resp_o ? s_rdata_i : '0;

      grant_o    = ~rst_i & (req_live ? owner : grant_q);
      err_o      = err_q & ~rst_i;
   end

endmodule

// File: tb/tb_sigma_bus_arb2.sv
module tb_sigma_bus_arb2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        m0_req, m0_we, m1_req, m1_we;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic [3:0]  m0_be, m1_be;
   logic        s_ack, s_resp;
   logic [31:0] s_rdata;

   logic        m0_ack, m0_resp, m1_ack, m1_resp, s_req, s_we, grant, err;
   logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
   logic [3:0]  s_be;

   logic        f_m0_ack, f_m0_resp, f_m1_ack, f_m1_resp, f_s_req, f_s_we, f_grant, f_err;
   logic [31:0] f_m0_rdata, f_m1_rdata, f_s_addr, f_s_wdata;
   logic [3:0]  f_s_be;

   sigma_bus_arb2 #(.ADDR_W(32), .DATA_W(32), .MAX_OUTST(4), .RR_EN(1'b1)) dut (
      .clk_i(clk), .rst_i(rst),
      .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_be_i(m0_be),
      .m0_wdata_i(m0_wdata), .m0_ack_o(m0_ack), .m0_resp_o(m0_resp), .m0_rdata_o(m0_rdata),
      .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_be_i(m1_be),
      .m1_wdata_i(m1_wdata), .m1_ack_o(m1_ack), .m1_resp_o(m1_resp), .m1_rdata_o(m1_rdata),
      .s_req_o(s_req), .s_we_o(s_we), .s_addr_o(s_addr), .s_be_o(s_be), .s_wdata_o(s_wdata),
      .s_ack_i(s_ack), .s_resp_i(s_resp), .s_rdata_i(s_rdata),
      .grant_o(grant), .err_o(err)
   );

   sigma_bus_arb2 #(.ADDR_W(32), .DATA_W(32), .MAX_OUTST(4), .RR_EN(1'b0)) dut_fp (
      .clk_i(clk), .rst_i(rst),
      .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_be_i(m0_be),
      .m0_wdata_i(m0_wdata), .m0_ack_o(f_m0_ack), .m0_resp_o(f_m0_resp),
      .m0_rdata_o(f_m0_rdata),
      .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_be_i(m1_be),
      .m1_wdata_i(m1_wdata), .m1_ack_o(f_m1_ack), .m1_resp_o(f_m1_resp),
      .m1_rdata_o(f_m1_rdata),
      .s_req_o(f_s_req), .s_we_o(f_s_we), .s_addr_o(f_s_addr), .s_be_o(f_s_be),
      .s_wdata_o(f_s_wdata),
      .s_ack_i(s_ack), .s_resp_i(s_resp), .s_rdata_i(s_rdata),
      .grant_o(f_grant), .err_o(f_err)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      m0_req = 0; m0_we = 0; m0_addr = '0; m0_be = '0; m0_wdata = '0;
      m1_req = 0; m1_we = 0; m1_addr = '0; m1_be = '0; m1_wdata = '0;
      s_ack = 0; s_resp = 0; s_rdata = '0;
   endtask

   task automatic drive(input int n, input logic req, input logic we,
                        input logic [31:0] addr, input logic [31:0] wdata);
      if (n == 0) begin
         m0_req = req; m0_we = we; m0_addr = addr; m0_be = 4'hF; m0_wdata = wdata;
      end else begin
         m1_req = req; m1_we = we; m1_addr = addr; m1_be = 4'hF; m1_wdata = wdata;
      end
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      idle_inputs();
      next_cycle();
      next_cycle();
      rst = 1'b0;
   endtask

   // Reference model state for the random phase.
   int          mq[$];
   bit          lock_v;
   int          lock_own, last_own, own, head;
   bit          pend[2], el[2];
   logic        r_we[2];
   logic [31:0] r_addr[2], r_wdata[2];
   logic [3:0]  r_be[2];
   bit          pop, space, exp_sreq;

   initial begin
      // Reset: everything quiet even with live inputs.
      rst = 1'b1;
      idle_inputs();
      drive(0, 1, 0, 32'h10, 0);
      s_ack = 1; s_resp = 1; s_rdata = 32'h1234;
      sample();
      chk1("rst_sreq", s_req, 1'b0);
      chk1("rst_grant", grant, 1'b0);
      chk1("rst_ack", m0_ack, 1'b0);
      chk1("rst_resp", m0_resp, 1'b0);
      chk1("rst_err", err, 1'b0);
      chk32("rst_saddr", s_addr, 32'h0);
      next_cycle();
      next_cycle();
      rst = 1'b0;
      idle_inputs();

      // Single m0 read, slave acks after 2 stall cycles, data 3 cycles later.
      drive(0, 1, 0, 32'h10, 0);
      for (int c = 0; c < 2; c++) begin
         sample();
         chk1("t1_sreq", s_req, 1'b1);
         chk32("t1_addr", s_addr, 32'h10);
         chk1("t1_noack", m0_ack, 1'b0);
         next_cycle();
      end
      s_ack = 1;
      sample();
      chk1("t1_ack", m0_ack, 1'b1);
      chk1("t1_m1ack", m1_ack, 1'b0);
      chk1("t1_grant", grant, 1'b0);
      next_cycle();
      drive(0, 0, 0, 0, 0);
      s_ack = 0;
      for (int c = 0; c < 2; c++) begin
         sample();
         chk1("t1_ack_once", m0_ack, 1'b0);
         chk1("t1_resp_early", m0_resp, 1'b0);
         next_cycle();
      end
      s_resp = 1; s_rdata = 32'hDEADBEEF;
      sample();
      chk1("t1_resp", m0_resp, 1'b1);
      chk32("t1_rdata", m0_rdata, 32'hDEADBEEF);
      chk1("t1_m1resp", m1_resp, 1'b0);
      chk32("t1_m1rdata", m1_rdata, 32'h0);
      next_cycle();
      s_resp = 0;
      sample();
      chk1("t1_resp_once", m0_resp, 1'b0);
      chk1("t1_err", err, 1'b0);
      next_cycle();

      // Both masters read every cycle, slave always acks and answers.
      reset_dut();
      drive(0, 1, 0, 32'hA0, 0);
      drive(1, 1, 0, 32'hB0, 0);
      s_ack = 1;
      for (int i = 0; i < 8; i++) begin
         s_resp = (i > 0);
         s_rdata = 32'(i) + 32'h100;
         sample();
         chk1("t2_grant_rr", grant, 1'(i % 2));
         chk1("t2_grant_fp", f_grant, 1'b0);
         chk1("t2_ack0", m0_ack, 1'(i % 2 == 0));
         chk1("t2_ack1", m1_ack, 1'(i % 2 == 1));
         chk1("t2_resp0", m0_resp, 1'(i > 0 && (i - 1) % 2 == 0));
         chk1("t2_resp1", m1_resp, 1'(i > 0 && (i - 1) % 2 == 1));
         chk1("t2_fp_resp0", f_m0_resp, 1'(i > 0));
         next_cycle();
      end

      // m1 write stalled 4 cycles while m0 requests.
      reset_dut();
      drive(1, 1, 1, 32'h80000000, 32'h5A5A5A5A);
      for (int c = 0; c < 4; c++) begin
         sample();
         chk1("t3_sreq", s_req, 1'b1);
         chk1("t3_grant", grant, 1'b1);
         chk1("t3_we", s_we, 1'b1);
         chk32("t3_addr", s_addr, 32'h80000000);
         chk32("t3_wdata", s_wdata, 32'h5A5A5A5A);
         chk32("t3_be", 32'(s_be), 32'hF);
         chk1("t3_m0_noack", m0_ack, 1'b0);
         next_cycle();
         drive(0, 1, 0, 32'h100, 0);
      end
      s_ack = 1;
      sample();
      chk1("t3_m1ack", m1_ack, 1'b1);
      chk1("t3_m0ack_hold", m0_ack, 1'b0);
      next_cycle();
      drive(1, 0, 0, 0, 0);
      sample();
      chk1("t3_m0_grant", grant, 1'b0);
      chk1("t3_m0_ack", m0_ack, 1'b1);
      chk32("t3_m0_addr", s_addr, 32'h100);
      chk1("t3_m0_we", s_we, 1'b0);
      next_cycle();

      // Fill the ID queue with m0,m1,m0,m1 reads.
      reset_dut();
      s_ack = 1;
      for (int i = 0; i < 4; i++) begin
         drive(i % 2, 1, 0, 32'h200 + 32'(i), 0);
         sample();
         chk1("t4_fill_ack", (i % 2 == 0) ? m0_ack : m1_ack, 1'b1);
         next_cycle();
         drive(i % 2, 0, 0, 0, 0);
      end
      drive(0, 1, 0, 32'h300, 0);
      sample();
      chk1("t4_full_block", s_req, 1'b0);
      chk1("t4_full_noack", m0_ack, 1'b0);
      next_cycle();
      drive(1, 1, 1, 32'h400, 32'hCAFE0001);
      sample();
      chk1("t4_wr_pass", s_req, 1'b1);
      chk1("t4_wr_we", s_we, 1'b1);
      chk1("t4_wr_grant", grant, 1'b1);
      chk1("t4_wr_ack", m1_ack, 1'b1);
      chk1("t4_rd_still_blocked", m0_ack, 1'b0);
      next_cycle();
      drive(1, 0, 0, 0, 0);
      s_resp = 1; s_rdata = 32'hA1A1A1A1;
      sample();
      chk1("t4_same_cycle_sreq", s_req, 1'b1);
      chk1("t4_same_cycle_ack", m0_ack, 1'b1);
      chk1("t4_first_resp", m0_resp, 1'b1);
      chk32("t4_first_rdata", m0_rdata, 32'hA1A1A1A1);
      chk32("t4_first_m1rdata", m1_rdata, 32'h0);
      next_cycle();
      s_resp = 0;
      sample();
      chk1("t4_still_full", s_req, 1'b0);
      next_cycle();
      drive(0, 0, 0, 0, 0);
      s_ack = 0;
      for (int i = 0; i < 4; i++) begin
         s_resp = 1; s_rdata = 32'hB0 + 32'(i);
         sample();
         chk1("t4_order_m0", m0_resp, 1'(i % 2 == 1));
         chk1("t4_order_m1", m1_resp, 1'(i % 2 == 0));
         chk32("t4_order_rdata", (i % 2 == 0) ? m1_rdata : m0_rdata, 32'hB0 + 32'(i));
         chk32("t4_other_rdata", (i % 2 == 0) ? m0_rdata : m1_rdata, 32'h0);
         next_cycle();
      end

      // Response with an empty queue.
      s_resp = 1; s_rdata = 32'hFFFF0000;
      sample();
      chk1("t5_drop_m0", m0_resp, 1'b0);
      chk1("t5_drop_m1", m1_resp, 1'b0);
      next_cycle();
      s_resp = 0;
      sample();
      chk1("t5_err_set", err, 1'b1);
      next_cycle();
      sample();
      chk1("t5_err_sticky", err, 1'b1);
      next_cycle();

      // Reset while locked with a read outstanding.
      s_ack = 1;
      drive(1, 1, 0, 32'h500, 0);
      sample();
      chk1("t6_m1_rd_ack", m1_ack, 1'b1);
      next_cycle();
      drive(1, 0, 0, 0, 0);
      s_ack = 0;
      drive(0, 1, 1, 32'h600, 32'h77);
      sample();
      chk1("t6_lock_sreq", s_req, 1'b1);
      next_cycle();
      rst = 1'b1;
      drive(0, 0, 0, 0, 0);
      sample();
      chk1("t6_rst_sreq", s_req, 1'b0);
      chk1("t6_rst_err", err, 1'b0);
      next_cycle();
      rst = 1'b0;
      sample();
      chk1("t6_post_sreq", s_req, 1'b0);
      chk1("t6_post_err", err, 1'b0);
      chk1("t6_post_grant", grant, 1'b0);
      next_cycle();
      s_resp = 1; s_rdata = 32'h55;
      sample();
      chk1("t6_stale_resp", m1_resp, 1'b0);
      next_cycle();
      s_resp = 0;
      sample();
      chk1("t6_stale_err", err, 1'b1);
      next_cycle();

      // Randomized traffic against a transaction-level model.
      reset_dut();
      mq.delete();
      lock_v = 0; last_own = 1; pend[0] = 0; pend[1] = 0;
      for (int cyc = 0; cyc < 500; cyc++) begin
         for (int n = 0; n < 2; n++) begin
            if (!pend[n] && $urandom_range(0, 1) == 1) begin
               pend[n]    = 1;
               r_we[n]    = 1'($urandom_range(0, 2) == 0);
               r_addr[n]  = $urandom;
               r_wdata[n] = $urandom;
               r_be[n]    = 4'($urandom_range(0, 15));
            end
         end
         m0_req = pend[0]; m0_we = r_we[0]; m0_addr = r_addr[0];
         m0_be = r_be[0]; m0_wdata = r_wdata[0];
         m1_req = pend[1]; m1_we = r_we[1]; m1_addr = r_addr[1];
         m1_be = r_be[1]; m1_wdata = r_wdata[1];
         s_ack   = ($urandom_range(0, 3) != 0);
         s_resp  = (mq.size() > 0) && ($urandom_range(0, 2) == 0);
         s_rdata = $urandom;

         pop   = s_resp && (mq.size() > 0);
         head  = pop ? mq[0] : 0;
         space = (mq.size() < 4) || pop;
         for (int n = 0; n < 2; n++) el[n] = pend[n] && (r_we[n] || space);
         if (lock_v) begin
            own = lock_own;
            exp_sreq = el[own];
         end else begin
            if (el[0] && el[1]) own = (last_own == 0) ? 1 : 0;
            else own = el[1] ? 1 : 0;
            exp_sreq = el[0] || el[1];
         end

         sample();
         chk1("r_sreq", s_req, exp_sreq);
         chk1("r_ack0", m0_ack, 1'(exp_sreq && s_ack && own == 0));
         chk1("r_ack1", m1_ack, 1'(exp_sreq && s_ack && own == 1));
         chk1("r_resp0", m0_resp, 1'(pop && head == 0));
         chk1("r_resp1", m1_resp, 1'(pop && head == 1));
         chk32("r_rdata0", m0_rdata, (pop && head == 0) ? s_rdata : 32'h0);
         chk32("r_rdata1", m1_rdata, (pop && head == 1) ? s_rdata : 32'h0);
         chk32("r_saddr", s_addr, exp_sreq ? r_addr[own] : 32'h0);
         chk1("r_swe", s_we, exp_sreq && r_we[own]);
         if (exp_sreq) chk1("r_grant", grant, 1'(own));
         chk1("r_err", err, 1'b0);

         if (pop) void'(mq.pop_front());
         if (exp_sreq && s_ack) begin
            if (!r_we[own]) mq.push_back(own);
            last_own  = own;
            lock_v    = 0;
            pend[own] = 0;
         end else if (exp_sreq) begin
            lock_v   = 1;
            lock_own = own;
         end
         next_cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sigma_bus_arb2.md
# sigma_bus_arb2

Two-master, one-slave bus arbiter for the sigma SoC. It shares the single system-bus slave port (RAM/CSR interconnect) between the CPU data port (master 0) and the UDM debug master (master 1). It performs round-robin or fixed-priority grant, holds each grant until the slave accepts the request, and routes in-order read responses back to the issuing master through a small ID queue.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte-enable width is DATA_W/8
- MAX_OUTST, 4, maximum outstanding reads (ID queue depth, power of 2, ≥2)
- RR_EN, 1, 1 = round-robin; 0 = fixed priority, m0 wins
- clk_i  in  1  system clock
- rst_i  in  1  synchronous, active-high reset
- mN_req_i (N=0,1)  in  1  request valid
- mN_we_i  in  1  1 = write, 0 = read
- mN_addr_i  in  ADDR_W  address
- mN_be_i  in  DATA_W/8  byte enables
- mN_wdata_i  in  DATA_W  write data
- mN_ack_o  out  1  request accepted this cycle
- mN_resp_o  out  1  read data valid
- mN_rdata_o  out  DATA_W  read data
- s_req_o  out  1  request to slave
- s_we_o, s_addr_o, s_be_o, s_wdata_o  out  1/ADDR_W/DATA_W/8/DATA_W  muxed request fields
- s_ack_i  in  1  slave accepted request
- s_resp_i  in  1  slave read data valid, in request order
- s_rdata_i  in  DATA_W  slave read data
- grant_o  out  1  current owner (0 = m0, 1 = m1)
- err_o  out  1  sticky: s_resp_i arrived while ID queue empty

## Operation
- States: IDLE (no grant held) and LOCKED (grant held, owner registered in grant_q).
- IDLE with any request: winner chosen combinationally. With RR_EN=1 and both requesting, the winner is the master not recorded in last_q; with RR_EN=0 it is m0. Request fields are forwarded in the same cycle.
- If s_ack_i=0 on the grant cycle, go to LOCKED with the owner fixed. The slave sees stable fields until it acks, even if the other master requests.
- mN_ack_o = s_ack_i & s_req_o & (owner==N). On ack, last_q <= owner and the state returns to IDLE. Back-to-back grants are allowed the next cycle.
- Reads (we=0) push the owner ID into the ID queue on ack. Writes push nothing.
- Queue full: s_req_o is forced to 0 for reads, and no new read grant is issued. Writes still pass. In LOCKED with a read pending, s_req_o is held low until the queue has space.
- s_resp_i: the head ID selects the master. That master gets mN_resp_o=1 and mN_rdata_o=s_rdata_i, and the head is popped. rdata_o of the non-selected master is 0.
- Push and pop in the same cycle are both performed; occupancy is unchanged. This is legal when the queue is full.
- s_resp_i with the queue empty: the response is dropped, no master resp is raised, and err_o is set. err_o is cleared only by reset.

## Timing
- Request path is combinational (0-cycle latency): mN_req_i to s_req_o; s_ack_i to mN_ack_o.
- Response path is combinational: s_resp_i to mN_resp_o, 0 cycles.
- Reset values: state=IDLE, last_q=1 (so m0 wins the first tie), queue empty, err_o=0, grant_o=0.
- All outputs are 0 during reset, except the s_* request fields, which are 0 whenever s_req_o=0.
- Reset mid-transaction: the lock is released and queued IDs are discarded. Responses arriving after reset raise err_o.
- A master must hold req and fields stable until its ack. Dropping req while LOCKED is a master protocol violation and is not supported.

## Structure
- Package sigma_bus_arb2_pkg holds:
  - typedef mid_t (1 bit)
  - state enum {IDLE, LOCKED}
  - localparams M_CPU=0 and M_UDM=1
- Sub-module sigma_bus_arb2_idq: synchronous FIFO of mid_t, depth MAX_OUTST, with push/pop/full/empty and pointer wrap. It is reset by rst_i.

## Test plan
- m0 read 0x00000010 alone; slave acks after 2 cycles and responds with 0xDEADBEEF 3 cycles later → m0_ack_o once, m0_resp_o once with 0xDEADBEEF, m1 outputs 0.
- m0 and m1 both read every cycle, slave always acks → grants alternate 0,1,0,1. With RR_EN=0, m0 wins every time.
- m1 write 0x80000000=0x5A5A5A5A with be=0xF, slave stalls 4 cycles while m0 requests → s_* fields stay m1's and constant; m0 is granted the cycle after m1's ack.
- MAX_OUTST=4, 4 reads acked with no response → 5th read is blocked (s_req_o=0) while a write passes. The 5th read proceeds once the 1st response arrives; responses return to the issuers in order.
- Response and new read ack in the same cycle at full occupancy → occupancy stays 4, no ID is lost.
- s_resp_i with an empty queue → err_o=1 and stays set; rst_i mid-LOCK → s_req_o=0 next cycle and err_o=0.
